// File: rtl/note_key_tracker_if.sv
// Scancode input and note-id output bundle of the note key tracker.
// scan_valid is a one-clock strobe with no back-pressure: the tracker accepts every byte it is given.
interface note_key_tracker_if;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic [4:0] freq_id1;
  logic [4:0] freq_id2;
  logic       new_f;
  logic [1:0] held;
  logic [1:0] parser_state;

  modport master (
    output scan_code, scan_valid,
    input  freq_id1, freq_id2, new_f, held, parser_state
  );

  modport slave (
    input  scan_code, scan_valid,
    output freq_id1, freq_id2, new_f, held, parser_state
  );
endinterface

// File: rtl/note_key_tracker.sv
// Decodes PS/2 Set-2 scancodes into up to two held note ids and publishes
// slot changes with a rate-limited one-clock new_f strobe.
module note_key_tracker #(
  parameter int MIN_GAP = 1300000,
  parameter int GAP_W   = 21
) (
  input logic          clock,
  input logic          reset,
  note_key_tracker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXTBRK} parse_t;

  localparam logic [4:0] NO_NOTE = 5'd31;
  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_EXT = 8'hE0;
  // Gap is loaded one short so strobes land exactly MIN_GAP clocks apart.
  localparam logic [GAP_W-1:0] GAP_LOAD = (MIN_GAP > 0) ? GAP_W'(MIN_GAP - 1) : '0;

  parse_t           state;
  logic [4:0]       slot1, slot2;
  logic [4:0]       code_id, slot1_n, slot2_n;
  logic             pending;
  logic [GAP_W-1:0] gap;
  logic             is_make, is_break, slot_change, publish;
  logic [1:0]       held_n;

  function automatic logic [4:0] key_id(input logic [7:0] code);
    case (code)
      8'h1A: key_id = 5'd0;   8'h1B: key_id = 5'd1;   8'h22: key_id = 5'd2;
      8'h23: key_id = 5'd3;   8'h21: key_id = 5'd4;   8'h2A: key_id = 5'd5;
      8'h34: key_id = 5'd6;   8'h32: key_id = 5'd7;   8'h33: key_id = 5'd8;
      8'h31: key_id = 5'd9;   8'h3B: key_id = 5'd10;  8'h3A: key_id = 5'd11;
      8'h41: key_id = 5'd12;  8'h15: key_id = 5'd13;  8'h1E: key_id = 5'd14;
      8'h1D: key_id = 5'd15;  8'h26: key_id = 5'd16;  8'h24: key_id = 5'd17;
      8'h2D: key_id = 5'd18;  8'h2E: key_id = 5'd19;  8'h2C: key_id = 5'd20;
      8'h36: key_id = 5'd21;  8'h35: key_id = 5'd22;  8'h3D: key_id = 5'd23;
      8'h3C: key_id = 5'd24;
      default: key_id = NO_NOTE;
    endcase
  endfunction

  always_comb begin
    code_id  = key_id(bus.scan_code);
    is_make  = bus.scan_valid && (state == IDLE) && (bus.scan_code != CODE_BRK) &&
               (bus.scan_code != CODE_EXT) && (code_id != NO_NOTE);
    is_break = bus.scan_valid && (state == BRK) && (code_id != NO_NOTE);
    slot1_n  = slot1;
    slot2_n  = slot2;
    if (is_make) begin
      // A typematic repeat of an already-held note leaves both slots alone.
      if ((code_id != slot1) && (code_id != slot2)) begin
        if (slot1 == NO_NOTE) slot1_n = code_id;
        else                  slot2_n = code_id;
      end
    end else if (is_break) begin
      if (code_id == slot1) begin
        slot1_n = slot2;
        slot2_n = NO_NOTE;
      end else if (code_id == slot2) begin
        slot2_n = NO_NOTE;
      end
    end
    slot_change = (slot1_n != slot1) || (slot2_n != slot2);
    publish     = pending && (gap == '0);
    held_n      = 2'(slot1_n != NO_NOTE) + 2'(slot2_n != NO_NOTE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      slot1        <= NO_NOTE;
      slot2        <= NO_NOTE;
      pending      <= 1'b0;
      gap          <= '0;
      bus.freq_id1 <= NO_NOTE;
      bus.freq_id2 <= NO_NOTE;
      bus.new_f    <= 1'b0;
      bus.held     <= 2'd0;
    end else begin
      if (bus.scan_valid) begin
        case (state)
          IDLE:    if (bus.scan_code == CODE_BRK)      state <= BRK;
                   else if (bus.scan_code == CODE_EXT) state <= EXT;
          BRK:     state <= IDLE;
          EXT:     state <= (bus.scan_code == CODE_BRK) ? EXTBRK : IDLE;
          default: state <= IDLE;
        endcase
      end
      slot1     <= slot1_n;
      slot2     <= slot2_n;
      bus.held  <= held_n;
      bus.new_f <= publish;
      // Publishing snapshots the pre-change slots; a same-clock change keeps pending set.
      if (publish) begin
        bus.freq_id1 <= slot1;
        bus.freq_id2 <= slot2;
        gap          <= GAP_LOAD;
      end else if (gap != '0) begin
        gap <= gap - 1'b1;
      end
      pending <= slot_change || (pending && !publish);
    end
  end

  assign bus.parser_state = state;

endmodule

// File: tb/tb_note_key_tracker.sv
// Bench for note_key_tracker: two instances (no rate limit and MIN_GAP=100) share one scancode stream.
module tb_note_key_tracker;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  note_key_tracker_if i0 ();
  note_key_tracker_if i1 ();

  note_key_tracker #(.MIN_GAP(0),   .GAP_W(21)) u0 (.clock(clock), .reset(reset), .bus(i0.slave));
  note_key_tracker #(.MIN_GAP(100), .GAP_W(21)) u1 (.clock(clock), .reset(reset), .bus(i1.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: held notes kept oldest-first in a queue, strobes timed from cycle stamps.
  logic [7:0] keys [25] = '{8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h32, 8'h33,
                            8'h31, 8'h3B, 8'h3A, 8'h41, 8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24,
                            8'h2D, 8'h2E, 8'h2C, 8'h36, 8'h35, 8'h3D, 8'h3C};
  int         notes[$];
  bit         saw_brk, saw_ext;
  bit         pend[2];
  int         last[2];
  int         gapv[2] = '{0, 100};
  logic [4:0] e1[2], e2[2];
  logic       enf[2];
  int         cyc = 0;
  logic [9:0] exp_q[$];
  int         strobe_cyc[$];
  logic [9:0] strobe_pair[$];

  function automatic int lookup(input logic [7:0] c);
    for (int i = 0; i < 25; i++) if (keys[i] == c) return i;
    return 31;
  endfunction

  function automatic logic [4:0] first_note();
    return (notes.size() > 0) ? 5'(notes[0]) : 5'd31;
  endfunction

  function automatic logic [4:0] second_note();
    return (notes.size() > 1) ? 5'(notes[1]) : 5'd31;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_step(input logic [7:0] code, input logic valid, input logic rst);
    int  id;
    bit  changed;
    cyc++;
    if (rst) begin
      notes.delete();
      saw_brk = 0; saw_ext = 0;
      for (int d = 0; d < 2; d++) begin
        pend[d] = 0; last[d] = -1; e1[d] = 5'd31; e2[d] = 5'd31; enf[d] = 1'b0;
      end
      return;
    end
    for (int d = 0; d < 2; d++) begin
      enf[d] = 1'b0;
      if (pend[d] && (last[d] < 0 || cyc - last[d] >= gapv[d])) begin
        e1[d] = first_note(); e2[d] = second_note(); enf[d] = 1'b1;
        pend[d] = 0; last[d] = cyc;
        if (d == 1) exp_q.push_back({e1[d], e2[d]});
      end
    end
    if (!valid) return;
    id = lookup(code);
    changed = 0;
    if (!saw_brk && !saw_ext) begin
      if (code == 8'hF0) saw_brk = 1;
      else if (code == 8'hE0) saw_ext = 1;
      else if (id != 31) begin
        bit found = 0;
        foreach (notes[i]) if (notes[i] == id) found = 1;
        if (!found) begin
          if (notes.size() < 2) notes.push_back(id);
          else notes[1] = id;
          changed = 1;
        end
      end
    end else if (saw_brk && !saw_ext) begin
      saw_brk = 0;
      for (int i = 0; i < notes.size(); i++) begin
        if (notes[i] == id) begin
          notes.delete(i);
          changed = 1;
          break;
        end
      end
    end else if (saw_ext && !saw_brk) begin
      if (code == 8'hF0) saw_brk = 1;
      else saw_ext = 0;
    end else begin
      saw_ext = 0; saw_brk = 0;
    end
    if (changed) begin
      pend[0] = 1; pend[1] = 1;
    end
  endtask

  task automatic check_all();
    logic [9:0] exp_pair;
    chk("u0_id1",  i0.freq_id1, e1[0]);
    chk("u0_id2",  i0.freq_id2, e2[0]);
    chk("u0_newf", i0.new_f,    enf[0]);
    chk("u0_held", i0.held,     notes.size());
    chk("u1_id1",  i1.freq_id1, e1[1]);
    chk("u1_id2",  i1.freq_id2, e2[1]);
    chk("u1_newf", i1.new_f,    enf[1]);
    chk("u1_held", i1.held,     notes.size());
    if (i1.new_f === 1'b1) begin
      strobe_cyc.push_back(cyc);
      strobe_pair.push_back({i1.freq_id1, i1.freq_id2});
      chk("u1_strobe_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        exp_pair = exp_q.pop_front();
        chk("u1_strobe_pair", {i1.freq_id1, i1.freq_id2}, exp_pair);
      end
    end
  endtask

  task automatic tick(input logic [7:0] code, input logic valid, input logic rst);
    i0.scan_code = code; i0.scan_valid = valid;
    i1.scan_code = code; i1.scan_valid = valid;
    reset = rst;
    @(posedge clock);
    model_step(code, valid, rst);
    #1;
    check_all();
    i0.scan_valid = 1'b0;
    i1.scan_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] code);
    tick(code, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) tick(8'h00, 1'b0, 1'b1);
  endtask

  logic [7:0] pool [10] = '{8'h1A, 8'h15, 8'h1D, 8'h3C, 8'h22, 8'hF0, 8'hF0, 8'hE0, 8'h5A, 8'h24};

  initial begin
    reset = 1'b1;
    i0.scan_code = 8'h00; i0.scan_valid = 1'b0;
    i1.scan_code = 8'h00; i1.scan_valid = 1'b0;

    do_reset(3);
    chk("reset_id1",  i0.freq_id1, 5'd31);
    chk("reset_id2",  i0.freq_id2, 5'd31);
    chk("reset_newf", i0.new_f,    1'b0);
    chk("reset_held", i0.held,     2'd0);

    // T1: first make, strobe two clocks after the byte
    send(8'h1A);
    chk("t1_no_early_strobe", i0.new_f, 1'b0);
    idle(1);
    chk("t1_newf", i0.new_f,    1'b1);
    chk("t1_id1",  i0.freq_id1, 5'd0);
    chk("t1_id2",  i0.freq_id2, 5'd31);
    chk("t1_held", i0.held,     2'd1);
    idle(1);
    chk("t1_newf_one_clock", i0.new_f, 1'b0);

    // T2: second note, then a typematic repeat
    send(8'h15); idle(1);
    chk("t2_id2", i0.freq_id2, 5'd13);
    send(8'h1A); idle(3);
    chk("t2_repeat_no_strobe", i0.new_f, 1'b0);
    chk("t2_held", i0.held, 2'd2);

    // T3: third note replaces slot 2; releasing slot 1 shifts slot 2 up
    send(8'h3C); idle(1);
    chk("t3_replace_id2", i0.freq_id2, 5'd24);
    send(8'hF0); send(8'h1A); idle(1);
    chk("t3_break_id1",  i0.freq_id1, 5'd24);
    chk("t3_break_id2",  i0.freq_id2, 5'd31);
    chk("t3_break_held", i0.held,     2'd1);

    // T4: extended and unmapped codes are ignored
    send(8'hE0); send(8'h1A);
    send(8'hE0); send(8'hF0); send(8'h3C);
    send(8'h5A); send(8'hF0); send(8'h5A); idle(2);
    chk("t4_held", i0.held, 2'd1);
    chk("t4_id1",  i0.freq_id1, 5'd24);
    send(8'h1A); idle(1);
    chk("t4_parser_idle_make", i0.held, 2'd2);

    // T5: rate limit and coalescing on the MIN_GAP=100 instance
    do_reset(2);
    strobe_cyc.delete(); strobe_pair.delete();
    send(8'h1A); send(8'h15); send(8'h1D);
    for (int i = 0; i < 300 && strobe_cyc.size() < 2; i++) idle(1);
    chk("t5_strobe_count", strobe_cyc.size(), 2);
    if (strobe_cyc.size() >= 2) begin
      chk("t5_spacing",      strobe_cyc[1] - strobe_cyc[0], 100);
      chk("t5_first_pair",   strobe_pair[0], {5'd0, 5'd31});
      chk("t5_second_pair",  strobe_pair[1], {5'd0, 5'd15});
    end

    // T6: reset between a break prefix and its code
    do_reset(1);
    send(8'h1A); idle(2);
    send(8'hF0);
    do_reset(1);
    chk("t6_id1",  i0.freq_id1, 5'd31);
    chk("t6_id2",  i0.freq_id2, 5'd31);
    chk("t6_held", i0.held,     2'd0);
    send(8'h1A); idle(1);
    chk("t6_make_after_reset", i0.held, 2'd1);
    chk("t6_newf", i0.new_f, 1'b1);

    // Randomized stream against the reference model
    for (int i = 0; i < 1500; i++) begin
      tick(pool[$urandom_range(0, 9)], 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 199) == 0));
    end
    idle(150);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
